// File: rtl/anc_pkg.sv
// Shared definitions for the ANC saturation pipeline: default widths,
// frame FSM states and sign-magnitude helpers.
package anc_pkg;

  localparam int DEF_N_CH   = 2;
  localparam int DEF_DATA_W = 11;
  localparam int DEF_SAT_W  = 9;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // A sign-magnitude value is zero whenever its magnitude is zero (+0 or -0).
  function automatic logic sm_is_zero(input logic [31:0] mag);
    return (mag == 32'd0);
  endfunction

  // Sign bit of the negated value; a zero magnitude always negates to +0.
  function automatic logic sm_neg(input logic sign, input logic [31:0] mag);
    return sm_is_zero(mag) ? 1'b0 : ~sign;
  endfunction

endpackage

// File: rtl/sm_sub_sat.sv
// Combinational sign-magnitude subtractor y = a - b with magnitude clipping.
// -0 on either input behaves as 0 and the result is never -0.
module sm_sub_sat
  import anc_pkg::*;
#(
  parameter int W = DEF_DATA_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o,
  output logic         sat_o
);

  localparam logic [W-2:0] MAX_MAG = '1;

  logic              nb_sign;
  logic signed [W:0] a_val;
  logic signed [W:0] nb_val;
  logic signed [W:0] diff;
  logic        [W:0] abs_val;
  logic      [W-2:0] mag;

  // Convert to two's complement one bit wider, add a and -b, then clip back.
  always_comb begin
    nb_sign = sm_neg(b_i[W-1], 32'(b_i[W-2:0]));
    a_val   = $signed({2'b00, a_i[W-2:0]});
    if (a_i[W-1]) a_val = -a_val;
    nb_val  = $signed({2'b00, b_i[W-2:0]});
    if (nb_sign) nb_val = -nb_val;
    diff    = a_val + nb_val;
    abs_val = diff[W] ? $unsigned(-diff) : $unsigned(diff);
    sat_o   = (abs_val > {2'b00, MAX_MAG});
    mag     = sat_o ? MAX_MAG : abs_val[W-2:0];
    y_o     = {diff[W] & ~sm_is_zero(32'(mag)), mag};
  end

endmodule

// File: rtl/anc_saturation_pipe.sv
// Multi-channel ANC output stage: clips filter outputs to the DAC range on
// each frame strobe and computes per-channel error mic - audio serially.
module anc_saturation_pipe
  import anc_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SAT_W  = DEF_SAT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                   Clk_100M,
  input  logic                   Reset_n,
  input  logic                   FiltComplete_In,
  input  logic [N_CH*DATA_W-1:0] Filt_In,
  input  logic [N_CH*DATA_W-1:0] MicIn,
  input  logic                   Bypass,
  input  logic                   ClrStatus,
  output logic [N_CH*DATA_W-1:0] ANCAudioOut,
  output logic [N_CH*DATA_W-1:0] Err,
  output logic                   ErrValid,
  output logic                   Busy,
  output logic [N_CH-1:0]        SatFlag,
  output logic [N_CH-1:0]        ErrSat,
  output logic                   Overrun,
  output logic [CNT_W-1:0]       SatCount
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
  localparam int PAD_W = DATA_W - 1 - SAT_W;

  logic                   old_q;
  logic                   start;
  logic                   frame_start;
  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N_CH*DATA_W-1:0] mic_q, audio_q, err_q, audio_clip;
  logic [N_CH-1:0]        sat_flag_q, err_sat_q, audio_sat;
  logic                   byp_q;
  logic                   overrun_q;
  logic [CNT_W-1:0]       sat_count_q;
  logic [DATA_W-1:0]      sub_a, sub_b, sub_y;
  logic                   sub_sat;

  assign start       = FiltComplete_In & ~old_q;
  assign frame_start = start & (state_q == IDLE);

  // Edge register resets high so a strobe held through reset is not an edge.
  always_ff @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) old_q <= 1'b1;
    else          old_q <= FiltComplete_In;
  end

  // Per-channel audio clip; identification mode forces +0 with no flag.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_clip
      logic [DATA_W-1:0] filt_ch;
      logic              over;
      assign filt_ch = Filt_In[gi*DATA_W +: DATA_W];
      assign over    = |filt_ch[DATA_W-2:SAT_W];
      assign audio_sat[gi] = over & ~Bypass;
      assign audio_clip[gi*DATA_W +: DATA_W] = Bypass ? '0 :
        {filt_ch[DATA_W-1], {PAD_W{1'b0}}, (over ? {SAT_W{1'b1}} : filt_ch[SAT_W-1:0])};
    end
  endgenerate

  // FSM state and channel index registers.
  always_ff @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: one CALC cycle per channel, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CALC;
        idx_d   = '0;
      end
      CALC: if (idx_q == LAST_IDX) state_d = DONE;
            else                   idx_d   = idx_q + 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM-derived outputs.
  always_comb begin
    Busy     = (state_q != IDLE);
    ErrValid = (state_q == DONE);
  end

  // One shared subtractor, steered to the channel being processed.
  assign sub_a = mic_q[idx_q*DATA_W +: DATA_W];
  assign sub_b = audio_q[idx_q*DATA_W +: DATA_W];

  sm_sub_sat #(.W(DATA_W)) u_sub (
    .a_i   (sub_a),
    .b_i   (sub_b),
    .y_o   (sub_y),
    .sat_o (sub_sat)
  );

  // Frame capture on the start edge, then one error channel per CALC cycle.
  always_ff @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) begin
      mic_q      <= '0;
      audio_q    <= '0;
      sat_flag_q <= '0;
      byp_q      <= 1'b0;
      err_q      <= '0;
      err_sat_q  <= '0;
    end else begin
      if (frame_start) begin
        mic_q      <= MicIn;
        audio_q    <= audio_clip;
        sat_flag_q <= audio_sat;
        byp_q      <= Bypass;
      end
      if (state_q == CALC) begin
        err_q[idx_q*DATA_W +: DATA_W] <= byp_q ? sub_a : sub_y;
        err_sat_q[idx_q]              <= ~byp_q & sub_sat;
      end
    end
  end

  // Sticky status; a set or increment takes priority over a clear.
  always_ff @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) begin
      overrun_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      if (start && (state_q != IDLE)) overrun_q <= 1'b1;
      else if (ClrStatus)             overrun_q <= 1'b0;
      if ((state_q == DONE) && (|sat_flag_q)) begin
        if (sat_count_q != '1) sat_count_q <= sat_count_q + 1'b1;
      end else if (ClrStatus) begin
        sat_count_q <= '0;
      end
    end
  end

  assign ANCAudioOut = audio_q;
  assign Err         = err_q;
  assign SatFlag     = sat_flag_q;
  assign ErrSat      = err_sat_q;
  assign Overrun     = overrun_q;
  assign SatCount    = sat_count_q;

endmodule

// File: tb/tb_anc_saturation_pipe.sv
// Self-checking bench for anc_saturation_pipe (N_CH=2, DATA_W=11, SAT_W=9).
module tb_anc_saturation_pipe;

  localparam int N_CH   = 2;
  localparam int DATA_W = 11;
  localparam int SAT_W  = 9;
  localparam int CNT_W  = 16;
  localparam logic [10:0] NEG0 = 11'h400;

  logic                   Clk_100M = 1'b0;
  logic                   Reset_n;
  logic                   FiltComplete_In;
  logic [N_CH*DATA_W-1:0] Filt_In;
  logic [N_CH*DATA_W-1:0] MicIn;
  logic                   Bypass;
  logic                   ClrStatus;
  logic [N_CH*DATA_W-1:0] ANCAudioOut;
  logic [N_CH*DATA_W-1:0] Err;
  logic                   ErrValid;
  logic                   Busy;
  logic [N_CH-1:0]        SatFlag;
  logic [N_CH-1:0]        ErrSat;
  logic                   Overrun;
  logic [CNT_W-1:0]       SatCount;

  always #5 Clk_100M = ~Clk_100M;

  anc_saturation_pipe #(.N_CH(N_CH), .DATA_W(DATA_W), .SAT_W(SAT_W), .CNT_W(CNT_W)) dut (
    .Clk_100M        (Clk_100M),
    .Reset_n         (Reset_n),
    .FiltComplete_In (FiltComplete_In),
    .Filt_In         (Filt_In),
    .MicIn           (MicIn),
    .Bypass          (Bypass),
    .ClrStatus       (ClrStatus),
    .ANCAudioOut     (ANCAudioOut),
    .Err             (Err),
    .ErrValid        (ErrValid),
    .Busy            (Busy),
    .SatFlag         (SatFlag),
    .ErrSat          (ErrSat),
    .Overrun         (Overrun),
    .SatCount        (SatCount)
  );

  typedef struct {
    logic [10:0] f0, f1, m0, m1;
    logic        byp;
    logic [10:0] a0, a1;
    logic [1:0]  sat;
    logic [10:0] e0, e1;
    logic [1:0]  esat;
  } vec_t;

  vec_t vecs[8];
  vec_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   sat_cnt_model = 0;

  function automatic logic [10:0] sm(input int v);
    return (v < 0) ? {1'b1, 10'(-v)} : {1'b0, 10'(v)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({ANCAudioOut, Err, ErrValid, Busy, SatFlag, ErrSat, Overrun, SatCount});
  endfunction

  task automatic tick();
    @(posedge Clk_100M);
    #1;
  endtask

  task automatic drive(input vec_t v);
    Filt_In = {v.f1, v.f0};
    MicIn   = {v.m1, v.m0};
    Bypass  = v.byp;
  endtask

  // Pop the oldest expected frame and compare it with the error outputs.
  task automatic check_err(input string tag);
    vec_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 128'(1), 128'(0));
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_err"}, 128'(Err), 128'({e.e1, e.e0}));
      chk({tag, "_errsat"}, 128'(ErrSat), 128'(e.esat));
    end
  endtask

  task automatic run_frame(input vec_t v, input int id);
    int got;
    string tag;
    tag = $sformatf("f%0d", id);
    drive(v);
    FiltComplete_In = 1'b1;
    sb_q.push_back(v);
    tick();
    FiltComplete_In = 1'b0;
    chk({tag, "_audio"}, 128'(ANCAudioOut), 128'({v.a1, v.a0}));
    chk({tag, "_satflag"}, 128'(SatFlag), 128'(v.sat));
    chk({tag, "_busy"}, 128'(Busy), 128'(1));
    if (v.sat != 2'b00 && sat_cnt_model < 65535) sat_cnt_model++;
    got = 0;
    for (int k = 1; k <= N_CH + 2; k++) begin
      tick();
      if (ErrValid) begin
        got++;
        chk({tag, "_latency"}, 128'(k), 128'(N_CH));
        check_err(tag);
      end
      if (k == N_CH + 1) begin
        chk({tag, "_busy_end"}, 128'(Busy), 128'(0));
        chk({tag, "_satcount"}, 128'(SatCount), 128'(sat_cnt_model));
      end
    end
    chk({tag, "_errvalid_cnt"}, 128'(got), 128'(1));
    $display("[TB] frame %0d audio=%h err=%h errsat=%b satcount=%0d", id, ANCAudioOut, Err, ErrSat, SatCount);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ev_cnt;
    int bad;

    //          f0        f1         m0         m1        byp   a0         a1         sat    e0          e1          esat
    vecs[0] = '{sm(300),  sm(-100),  sm(500),   sm(-40),  1'b0, sm(300),   sm(-100),  2'b00, sm(200),    sm(60),     2'b00};
    vecs[1] = '{sm(-700), sm(5),     sm(600),   sm(5),    1'b0, sm(-511),  sm(5),     2'b01, sm(1023),   sm(0),      2'b01};
    vecs[2] = '{sm(0),    NEG0,      NEG0,      sm(7),    1'b0, sm(0),     NEG0,      2'b00, sm(0),      sm(7),      2'b00};
    vecs[3] = '{sm(800),  sm(-3),    sm(123),   NEG0,     1'b1, sm(0),     sm(0),     2'b00, sm(123),    NEG0,       2'b00};
    vecs[4] = '{sm(1023), sm(-520),  sm(-1023), sm(0),    1'b0, sm(511),   sm(-511),  2'b11, sm(-1023),  sm(511),    2'b01};
    vecs[5] = '{sm(512),  sm(511),   sm(511),   sm(511),  1'b0, sm(511),   sm(511),   2'b01, sm(0),      sm(0),      2'b00};
    vecs[6] = '{sm(-100), sm(200),   sm(923),   sm(-823), 1'b0, sm(-100),  sm(200),   2'b00, sm(1023),   sm(-1023),  2'b00};
    vecs[7] = '{sm(-1),   sm(1),     sm(1023),  sm(-1023),1'b0, sm(-1),    sm(1),     2'b00, sm(1023),   sm(-1023),  2'b11};

    // Reset with the strobe held high; release must not start a frame.
    Reset_n = 1'b0; FiltComplete_In = 1'b1; Filt_In = '0; MicIn = '0;
    Bypass = 1'b0; ClrStatus = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", all_outs(), 128'(0));
    Reset_n = 1'b1;
    bad = 0;
    repeat (5) begin
      tick();
      if (Busy || ErrValid) bad++;
    end
    chk("reset_release_no_frame", 128'(bad), 128'(0));
    $display("[TB] reset release with strobe high: busy=%b", Busy);
    FiltComplete_In = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i], i);
      tick();
    end

    // Overrun: second edge while the frame is still in CALC.
    drive(vecs[0]);
    FiltComplete_In = 1'b1;
    sb_q.push_back(vecs[0]);
    tick();
    FiltComplete_In = 1'b0;
    tick();
    FiltComplete_In = 1'b1;
    Filt_In = {sm(9), sm(9)};
    MicIn   = {sm(1), sm(1)};
    tick();
    chk("ovr_calc_overrun", 128'(Overrun), 128'(1));
    ev_cnt = 0;
    if (ErrValid) begin ev_cnt++; check_err("ovr_calc"); end
    FiltComplete_In = 1'b0;
    repeat (4) begin
      tick();
      if (ErrValid) begin ev_cnt++; check_err("ovr_calc"); end
    end
    chk("ovr_calc_errvalid_cnt", 128'(ev_cnt), 128'(1));
    chk("ovr_calc_idle", 128'(Busy), 128'(0));
    $display("[TB] overrun in CALC: overrun=%b err=%h", Overrun, Err);

    ClrStatus = 1'b1;
    tick();
    ClrStatus = 1'b0;
    sat_cnt_model = 0;
    chk("clr_overrun", 128'(Overrun), 128'(0));
    chk("clr_satcount", 128'(SatCount), 128'(0));
    $display("[TB] clear status: overrun=%b satcount=%0d", Overrun, SatCount);

    // Overrun edge during DONE, concurrent with ClrStatus: set/increment win.
    drive(vecs[1]);
    FiltComplete_In = 1'b1;
    sb_q.push_back(vecs[1]);
    tick();
    FiltComplete_In = 1'b0;
    tick();
    tick();
    chk("ovr_done_errvalid", 128'(ErrValid), 128'(1));
    if (ErrValid) check_err("ovr_done");
    FiltComplete_In = 1'b1;
    ClrStatus = 1'b1;
    tick();
    ClrStatus = 1'b0;
    chk("ovr_done_overrun", 128'(Overrun), 128'(1));
    chk("ovr_done_satcount", 128'(SatCount), 128'(1));
    chk("ovr_done_errvalid_gone", 128'(ErrValid), 128'(0));
    tick();
    chk("ovr_done_no_frame", 128'(Busy), 128'(0));
    FiltComplete_In = 1'b0;
    $display("[TB] overrun in DONE with clear: overrun=%b satcount=%0d", Overrun, SatCount);
    ClrStatus = 1'b1;
    tick();
    ClrStatus = 1'b0;
    chk("clr2_status", 128'({Overrun, SatCount}), 128'(0));

    // Asynchronous reset in the middle of CALC.
    drive(vecs[4]);
    FiltComplete_In = 1'b1;
    tick();
    tick();
    #2;
    Reset_n = 1'b0;
    #1;
    chk("midreset_outputs", all_outs(), 128'(0));
    tick();
    Reset_n = 1'b1;
    bad = 0;
    repeat (5) begin
      tick();
      if (Busy || ErrValid) bad++;
    end
    chk("midreset_no_frame", 128'(bad), 128'(0));
    FiltComplete_In = 1'b0;
    sat_cnt_model = 0;
    $display("[TB] mid-frame reset: busy=%b errvalid=%b", Busy, ErrValid);
    tick();

    run_frame(vecs[1], 8);
    chk("scoreboard_drained", 128'(sb_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
